// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC register and fetch-redirect controller.
// Steps PC by 4 and applies goto redirects, holding one redirect that
// arrives while stalled. Supports halt/go single-step and keeps
// run-cycle, branch and jump statistics counters.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   stall           hold PC this cycle (a goto is buffered)
//   halt, go        enter HALT / resume to RUN (go wins in HALT)
//   branch, jump    statistics strobes
//   goto, new_addr  redirect request and byte target
//   PC, PC_plus_1   current fetch address and PC+4
//   flush           one cycle after a redirect is loaded into PC
//   halted          state is HALT
//   cycle_cnt, branch_cnt, jump_cnt  wrapping statistics counters
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall,
    input  logic             halt,
    input  logic             go,
    input  logic             branch,
    input  logic             jump,
    input  logic             goto,
    input  logic [31:0]      new_addr,
    output logic [31:0]      PC,
    output logic [31:0]      PC_plus_1,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] jump_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic        pend_vld;
    logic        pend_vld_nxt;
    logic [31:0] pend_addr;
    logic [31:0] pend_addr_nxt;
    logic        flush_nxt;
    // High on RUN cycles that are not consumed by a halt request.
    logic        cnt_en;

    assign PC_plus_1 = PC + 32'd4;
    assign halted    = (state == HALT);

    always_comb begin
        state_nxt     = state;
        pc_nxt        = PC;
        pend_vld_nxt  = pend_vld;
        pend_addr_nxt = pend_addr;
        flush_nxt     = 1'b0;
        cnt_en        = 1'b0;
        unique case (state)
            RUN: begin
                if (halt) begin
                    state_nxt    = HALT;
                    pend_vld_nxt = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                    if (stall) begin
                        if (goto) begin
                            pend_addr_nxt = new_addr;
                            pend_vld_nxt  = 1'b1;
                        end
                    end else if (goto) begin
                        // A live redirect supersedes a buffered one.
                        pc_nxt       = {new_addr[31:2], 2'b00};
                        pend_vld_nxt = 1'b0;
                        flush_nxt    = 1'b1;
                    end else if (pend_vld) begin
                        pc_nxt       = {pend_addr[31:2], 2'b00};
                        pend_vld_nxt = 1'b0;
                        flush_nxt    = 1'b1;
                    end else begin
                        pc_nxt = PC + 32'd4;
                    end
                end
            end
            HALT: begin
                if (go) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            PC         <= RESET_PC;
            pend_vld   <= 1'b0;
            pend_addr  <= 32'h0;
            flush      <= 1'b0;
            cycle_cnt  <= '0;
            branch_cnt <= '0;
            jump_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            PC        <= pc_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_addr <= pend_addr_nxt;
            flush     <= flush_nxt;
            if (cnt_en) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            if (cnt_en && branch) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (cnt_en && jump) begin
                jump_cnt <= jump_cnt + CNT_ONE;
            end
        end
    end

endmodule
